mux21_2bits_rr_arbiter: RTL and testbench
=========================================

Name: mux21_2bits_rr_arbiter

Overview:
Round-robin arbiter and sequencer for the 2:1, 2-bit multiplexer datapath. It shares one registered output channel between two valid/ready requesters. It drives the mux select and captures the selected word into an output register. It sits in front of the mux and replaces static select wiring with handshaked, fair, back-pressure-aware sequencing.

Parameters:
WIDTH, 2, data width of each requester and of the output word
FIRST_GRANT, 0, channel granted first after reset when both request (0 or 1)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset; sampled on rising edge of clk
in0_valid  input  1  requester 0 has a word
in0_data  input  WIDTH  requester 0 word
in0_ready  output  1  requester 0 word accepted this cycle
in1_valid  input  1  requester 1 has a word
in1_data  input  WIDTH  requester 1 word
in1_ready  output  1  requester 1 word accepted this cycle
out_valid  output  1  output register holds a word
out_data  output  WIDTH  registered mux output
out_ready  input  1  downstream accepts out_data this cycle
selector  output  1  registered select of the word in the output register (0 = in0, 1 = in1)
busy  output  1  equals out_valid && !out_ready (stall indicator)

Behaviour:
- State machine, 2 states. EMPTY: out_valid=0. FULL: out_valid=1.
- load_en = (state==EMPTY) || out_ready.
- Grant is combinational from in0_valid, in1_valid and last_sel:
  - only in0_valid: grant 0.
  - only in1_valid: grant 1.
  - both valid: grant !last_sel.
  - neither: no grant.
- inN_ready = load_en && grant==N. At most one ready is high per cycle. Ready never depends on inN_ready.
- Accept: on load_en with a grant:
  - out_data <= granted inN_data
  - selector <= grant
  - last_sel <= grant
  - state <= FULL
- On load_en with no grant: state <= EMPTY, out_valid <= 0. out_data and selector hold their previous values.
- In FULL with out_ready=0: out_data, selector and last_sel hold; both inN_ready=0.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 word/cycle while out_ready=1. Simultaneous drain and refill in the same cycle gives no bubble.
- Fairness: under continuous dual requests the grants alternate 0,1,0,1,… A single active requester gets every slot; no idle slot is wasted.
- Reset (any cycle, including mid-stall):
  - state=EMPTY, out_valid=0, out_data=0, selector=0, busy=0
  - last_sel = !FIRST_GRANT
  - in0_ready=0 and in1_ready=0 during the reset cycle
  - a word held in the output register is discarded
- Requesters may drop valid without a handshake; the arbiter only samples at accept.
- No X propagation: out_data changes only on accept.

Optional Feature:
Macro MUX21_ARB_STATS_EN.
- Defined: adds outputs cnt0 and cnt1 (8 bits each).
  - Each counts accepted words for its channel.
  - Reset to 0.
  - Each increments on its inN_valid && inN_ready.
  - Wraps 255 -> 0.
  - Adds stall_cnt (8 bits): increments each cycle busy=1, saturates at 255, reset to 0.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset, then idle: reset=1 for 2 cycles, release, no valids -> out_valid=0, out_data=0, selector=0, in0_ready=in1_ready=0 after release.
- Single requester streaming: in0_valid=1 with data 0,1,2,3 on successive cycles, out_ready=1 -> out_data 0,1,2,3 one cycle later, back-to-back, selector=0 throughout.
- Dual contention, FIRST_GRANT=0: in0_data=2'b01 and in1_data=2'b10 held valid, out_ready=1 -> outputs 01,10,01,10, selector 0,1,0,1, ready alternates.
- Back-pressure: FULL with out_data=2'b11, out_ready=0 for 3 cycles -> out_data and selector stable, busy=1, both ready=0. out_ready=1 -> new word loaded the same cycle and next grant follows round-robin.
- Reset mid-stall: FULL, out_ready=0, assert reset 1 cycle -> next cycle out_valid=0, out_data=0, selector=0. With both valid, first grant is FIRST_GRANT.
- MUX21_ARB_STATS_EN defined: 300 accepts on in1 and 5 stall cycles -> cnt1=44 (wrapped), cnt0=0, stall_cnt=5.

Source files
------------

// File: rtl/mux21_2bits_rr_arbiter.sv
// mux21_2bits_rr_arbiter
// Round-robin arbiter and sequencer for the 2:1, 2-bit mux datapath. Two
// valid/ready requesters share one registered output channel. The arbiter
// picks a requester and drives the mux select. It captures the chosen word
// into the output register and tracks back-pressure from downstream.
//
// Parameters:
//   WIDTH        data width of each requester and of the output word
//   FIRST_GRANT  channel granted first after reset when both request
//
// Ports:
//   clk                   rising-edge clock
//   reset                 synchronous, active-high reset
//   in0_valid/data/ready  requester 0 handshake
//   in1_valid/data/ready  requester 1 handshake
//   out_valid/data/ready  registered output channel
//   selector              which requester supplied the word in the output register
//   busy                  output is stalled (out_valid && !out_ready)
//
// Optional build macro MUX21_ARB_STATS_EN adds these outputs:
//   cnt0, cnt1  wrapping per-channel accept counters
//   stall_cnt   saturating stall-cycle counter
module mux21_2bits_rr_arbiter #(
   parameter int WIDTH       = 2,
   parameter bit FIRST_GRANT = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in0_valid,
   input  logic [WIDTH-1:0] in0_data,
   output logic             in0_ready,
   input  logic             in1_valid,
   input  logic [WIDTH-1:0] in1_data,
   output logic             in1_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             selector,
`ifdef MUX21_ARB_STATS_EN
   output logic [7:0]       cnt0,
   output logic [7:0]       cnt1,
   output logic [7:0]       stall_cnt,
`endif
   output logic             busy
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t state;
   logic   last_sel;
   logic   load_en;
   logic   grant_valid;
   logic   grant;

   // When both requesters are valid, the grant goes to the channel that was
   // not served last. When only one is valid, that one wins. A lone
   // requester therefore gets every slot, and no slot is left idle.
   always_comb begin
      grant_valid = in0_valid || in1_valid;
      grant       = 1'b0;
      if (in0_valid && in1_valid)
         grant = !last_sel;
      else if (in1_valid)
         grant = 1'b1;
   end

   // The output register can take a new word when it is empty or when it is
   // draining in this cycle. Draining and refilling together gives full
   // throughput. Ready is masked during reset, so no word is accepted and
   // then thrown away.
   assign load_en   = (state == EMPTY) || out_ready;
   assign in0_ready = !reset && load_en && grant_valid && !grant;
   assign in1_ready = !reset && load_en && grant_valid &&  grant;

   assign out_valid = (state == FULL);
   assign busy      = out_valid && !out_ready;

   // Two-state output register. out_data and selector change only when a
   // word is accepted. When a load slot has no grant, only the valid flag is
   // cleared, and the stale word stays in the register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= EMPTY;
         out_data <= '0;
         selector <= 1'b0;
         last_sel <= !FIRST_GRANT;
      end else if (load_en) begin
         if (grant_valid) begin
            out_data <= grant ? in1_data : in0_data;
            selector <= grant;
            last_sel <= grant;
            state    <= FULL;
         end else begin
            state    <= EMPTY;
         end
      end
   end

`ifdef MUX21_ARB_STATS_EN
   // The accept counters wrap at 255. The stall counter saturates, so a long
   // stall cannot roll it back to a small value.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt0      <= 8'd0;
         cnt1      <= 8'd0;
         stall_cnt <= 8'd0;
      end else begin
         if (in0_valid && in0_ready)
            cnt0 <= cnt0 + 8'd1;
         if (in1_valid && in1_ready)
            cnt1 <= cnt1 + 8'd1;
         if (busy && (stall_cnt != 8'hFF))
            stall_cnt <= stall_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mux21_2bits_rr_arbiter.sv
// tb_mux21_2bits_rr_arbiter
// Scoreboard bench for mux21_2bits_rr_arbiter. Each directed vector carries
// the grant it should produce. A granted word is queued as {selector, data}.
// A separate monitor pops the queue on every output transfer and compares.
module tb_mux21_2bits_rr_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in0_valid = 1'b0;
   logic [1:0] in0_data = 2'd0;
   logic       in0_ready;
   logic       in1_valid = 1'b0;
   logic [1:0] in1_data = 2'd0;
   logic       in1_ready;
   logic       out_valid;
   logic [1:0] out_data;
   logic       out_ready = 1'b0;
   logic       selector;
   logic       busy;
`ifdef MUX21_ARB_STATS_EN
   logic [7:0] cnt0;
   logic [7:0] cnt1;
   logic [7:0] stall_cnt;
`endif

   int         tests_run = 0;
   int         tests_failed = 0;
   logic [2:0] sb[$];

   mux21_2bits_rr_arbiter #(.WIDTH(2), .FIRST_GRANT(1'b0)) dut (
      .clk(clk),
      .reset(reset),
      .in0_valid(in0_valid),
      .in0_data(in0_data),
      .in0_ready(in0_ready),
      .in1_valid(in1_valid),
      .in1_data(in1_data),
      .in1_ready(in1_ready),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_ready(out_ready),
      .selector(selector),
`ifdef MUX21_ARB_STATS_EN
      .cnt0(cnt0),
      .cnt1(cnt1),
      .stall_cnt(stall_cnt),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Monitor: every transfer on the output channel consumes one expected word.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         tests_run++;
         if (sb.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL out_word: got sel=%0d data=%0d, required none (queue empty)",
                     selector, out_data);
         end else begin
            logic [2:0] exp;
            exp = sb.pop_front();
            if ({selector, out_data} !== exp) begin
               tests_failed++;
               $display("[TB] FAIL out_word: got sel=%0d data=%0d, required sel=%0d data=%0d",
                        selector, out_data, exp[2], exp[1:0]);
            end
         end
      end
   end

   // Drives one cycle of inputs. At the falling edge it checks the ready
   // pair against the hand-computed grant and queues the granted word.
   task automatic applyStimulus(input logic rst, input logic v0, input logic [1:0] d0,
                                input logic v1, input logic [1:0] d1, input logic ordy,
                                input logic er0, input logic er1);
      @(posedge clk);
      #1;
      reset     = rst;
      in0_valid = v0;
      in0_data  = d0;
      in1_valid = v1;
      in1_data  = d1;
      out_ready = ordy;
      if (rst)
         sb.delete();
      @(negedge clk);
      tests_run++;
      if ({in1_ready, in0_ready} !== {er1, er0}) begin
         tests_failed++;
         $display("[TB] FAIL ready: got r1=%0b r0=%0b, required r1=%0b r0=%0b",
                  in1_ready, in0_ready, er1, er0);
      end
      if (er0)
         sb.push_back({1'b0, d0});
      if (er1)
         sb.push_back({1'b1, d1});
   endtask

   // Compares the registered outputs at the current falling edge.
   task automatic checkOutput(input string name, input logic ev, input logic [1:0] ed,
                              input logic es, input logic eb);
      tests_run++;
      if ({out_valid, out_data, selector, busy} !== {ev, ed, es, eb}) begin
         tests_failed++;
         $display("[TB] FAIL %s: got valid=%0b data=%0d sel=%0b busy=%0b, required valid=%0b data=%0d sel=%0b busy=%0b",
                  name, out_valid, out_data, selector, busy, ev, ed, es, eb);
      end
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset for two cycles. A request during reset must not be accepted.
      applyStimulus(1, 1, 2'd1, 1, 2'd2, 1, 0, 0);
      applyStimulus(1, 0, 2'd0, 0, 2'd0, 1, 0, 0);
      applyStimulus(0, 0, 2'd0, 0, 2'd0, 1, 0, 0);
      checkOutput("reset_idle", 0, 2'd0, 0, 0);
      applyStimulus(0, 0, 2'd0, 0, 2'd0, 1, 0, 0);
      checkOutput("idle", 0, 2'd0, 0, 0);

      // Single requester streaming 0..3 back to back.
      for (int i = 0; i < 4; i++)
         applyStimulus(0, 1, 2'(i), 0, 2'd0, 1, 1, 0);
      checkOutput("stream_last", 1, 2'd2, 0, 0);
      applyStimulus(0, 0, 2'd0, 0, 2'd0, 1, 0, 0);
      checkOutput("stream_tail", 1, 2'd3, 0, 0);
      applyStimulus(0, 0, 2'd0, 0, 2'd0, 1, 0, 0);
      checkOutput("empty_holds_data", 0, 2'd3, 0, 0);

      // Dual contention straight after reset: grants go 0,1,0,1.
      applyStimulus(1, 0, 2'd0, 0, 2'd0, 1, 0, 0);
      applyStimulus(0, 1, 2'b01, 1, 2'b10, 1, 1, 0);
      applyStimulus(0, 1, 2'b01, 1, 2'b10, 1, 0, 1);
      checkOutput("dual_first", 1, 2'b01, 0, 0);
      applyStimulus(0, 1, 2'b01, 1, 2'b10, 1, 1, 0);
      checkOutput("dual_second", 1, 2'b10, 1, 0);
      applyStimulus(0, 1, 2'b01, 1, 2'b10, 1, 0, 1);
      applyStimulus(0, 0, 2'd0, 0, 2'd0, 1, 0, 0);

      // Back-pressure: hold word 11 for three stalled cycles, then release.
      applyStimulus(1, 0, 2'd0, 0, 2'd0, 1, 0, 0);
      applyStimulus(0, 1, 2'b11, 0, 2'd0, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 2'b01, 1, 2'b10, 0, 0, 0);
         checkOutput("stall_hold", 1, 2'b11, 0, 1);
      end
      applyStimulus(0, 1, 2'b01, 1, 2'b10, 1, 0, 1);
      checkOutput("stall_release", 1, 2'b11, 0, 0);
      applyStimulus(0, 1, 2'b01, 1, 2'b10, 1, 1, 0);
      checkOutput("after_release", 1, 2'b10, 1, 0);

      // Reset mid-stall discards the held word. Then the first grant is channel 0.
      applyStimulus(0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
      checkOutput("stall_before_reset", 1, 2'b01, 0, 1);
      applyStimulus(1, 1, 2'b10, 1, 2'b01, 0, 0, 0);
      applyStimulus(0, 1, 2'b10, 1, 2'b01, 0, 1, 0);
      checkOutput("after_reset", 0, 2'd0, 0, 0);
      applyStimulus(0, 0, 2'd0, 0, 2'd0, 1, 0, 0);
      checkOutput("first_grant", 1, 2'b10, 0, 0);
      applyStimulus(0, 0, 2'd0, 0, 2'd0, 1, 0, 0);

`ifdef MUX21_ARB_STATS_EN
      // 300 accepts on channel 1 wrap cnt1 to 44. Five stall cycles follow.
      applyStimulus(1, 0, 2'd0, 0, 2'd0, 1, 0, 0);
      for (int i = 0; i < 300; i++)
         applyStimulus(0, 0, 2'd0, 1, 2'(i), 1, 0, 1);
      for (int i = 0; i < 5; i++)
         applyStimulus(0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
      applyStimulus(0, 0, 2'd0, 0, 2'd0, 1, 0, 0);
      tests_run++;
      if ({cnt0, cnt1, stall_cnt} !== {8'd0, 8'd44, 8'd5}) begin
         tests_failed++;
         $display("[TB] FAIL stats: got cnt0=%0d cnt1=%0d stall=%0d, required cnt0=0 cnt1=44 stall=5",
                  cnt0, cnt1, stall_cnt);
      end
      applyStimulus(0, 0, 2'd0, 0, 2'd0, 1, 0, 0);
`endif

      tests_run++;
      if (sb.size() != 0) begin
         tests_failed++;
         $display("[TB] FAIL scoreboard_drain: got %0d words left, required 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
